// File: rtl/simon_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : simon_seq_engine
// Description : Simon game engine. Records player patterns, plays the whole
//               sequence back, checks the repeat, and loops the sequence
//               forever on a failed repeat or a win.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_engine #(
  parameter int N_BTN       = 4,
  parameter int ADDR_W      = 6,
  parameter int STEP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              level,
  input  logic [N_BTN-1:0]  pattern,
  input  logic              enter,
  output logic [N_BTN-1:0]  pattern_leds,
  output logic [2:0]        mode_leds,
  output logic [ADDR_W:0]   seq_len,
  output logic              fail,
  output logic              full
);

  localparam int c_depth   = 2**ADDR_W;
  localparam int c_timer_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(STEP_CYCLES - 1);
  localparam logic [ADDR_W:0]      c_depth_len  = (ADDR_W+1)'(c_depth);

  localparam logic [2:0] c_mode_input    = 3'b001;
  localparam logic [2:0] c_mode_playback = 3'b010;
  localparam logic [2:0] c_mode_repeat   = 3'b100;
  localparam logic [2:0] c_mode_done     = 3'b111;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                 r_state;
  logic [N_BTN-1:0]       r_mem [c_depth];
  logic [ADDR_W-1:0]      r_play_idx;
  logic [ADDR_W-1:0]      r_rep_idx;
  logic [ADDR_W-1:0]      r_done_idx;
  logic [c_timer_w-1:0]   r_timer;

  logic                   w_onehot;
  logic                   w_legal;
  logic                   w_timer_exp;
  logic [ADDR_W:0]        w_seq_last;
  logic                   w_play_last;
  logic                   w_rep_last;
  logic                   w_done_last;
  logic [ADDR_W-1:0]      w_wr_idx;
  logic [N_BTN-1:0]       w_play_data;
  logic [N_BTN-1:0]       w_rep_data;
  logic [N_BTN-1:0]       w_done_data;

  assign w_onehot    = ((pattern & (pattern - 1'b1)) == '0);
  assign w_legal     = (pattern != '0) && (level || w_onehot);
  assign w_timer_exp = (r_timer == c_timer_last);

  // Index compares are done at ADDR_W+1 bits so a full sequence (seq_len == DEPTH) works.
  assign w_seq_last  = seq_len - (ADDR_W+1)'(1);
  assign w_play_last = ({1'b0, r_play_idx} == w_seq_last);
  assign w_rep_last  = ({1'b0, r_rep_idx}  == w_seq_last);
  assign w_done_last = ({1'b0, r_done_idx} == w_seq_last);
  assign w_wr_idx    = seq_len[ADDR_W-1:0];

  assign w_play_data = r_mem[r_play_idx];
  assign w_rep_data  = r_mem[r_rep_idx];
  assign w_done_data = r_mem[r_done_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INPUT;
      mode_leds    <= c_mode_input;
      pattern_leds <= '0;
      seq_len      <= '0;
      r_play_idx   <= '0;
      r_rep_idx    <= '0;
      r_done_idx   <= '0;
      r_timer      <= '0;
      fail         <= 1'b0;
      full         <= 1'b0;
    end else begin
      fail <= 1'b0;
      case (r_state)
        ST_INPUT: begin
          pattern_leds <= pattern;
          if (enter && w_legal && !full) begin
            r_mem[w_wr_idx] <= pattern;
            seq_len         <= seq_len + 1'b1;
            full            <= ((seq_len + 1'b1) == c_depth_len);
            r_play_idx      <= '0;
            r_timer         <= '0;
            r_state         <= ST_PLAYBACK;
            mode_leds       <= c_mode_playback;
          end
        end

        ST_PLAYBACK: begin
          if (w_timer_exp) begin
            r_timer <= '0;
            if (w_play_last) begin
              r_rep_idx    <= '0;
              pattern_leds <= '0;
              r_state      <= ST_REPEAT;
              mode_leds    <= c_mode_repeat;
            end else begin
              pattern_leds <= w_play_data;
              r_play_idx   <= r_play_idx + 1'b1;
            end
          end else begin
            pattern_leds <= w_play_data;
            r_timer      <= r_timer + 1'b1;
          end
        end

        ST_REPEAT: begin
          pattern_leds <= pattern;
          if (enter) begin
            if (pattern == w_rep_data) begin
              if (!w_rep_last) begin
                r_rep_idx <= r_rep_idx + 1'b1;
              end else if (full) begin
                r_done_idx <= '0;
                r_timer    <= '0;
                r_state    <= ST_DONE;
                mode_leds  <= c_mode_done;
              end else begin
                r_state    <= ST_INPUT;
                mode_leds  <= c_mode_input;
              end
            end else begin
              fail       <= 1'b1;
              r_done_idx <= '0;
              r_timer    <= '0;
              r_state    <= ST_DONE;
              mode_leds  <= c_mode_done;
            end
          end
        end

        ST_DONE: begin
          // Endless replay of the stored sequence; only rst leaves this state.
          pattern_leds <= w_done_data;
          if (w_timer_exp) begin
            r_timer    <= '0;
            r_done_idx <= w_done_last ? '0 : r_done_idx + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state   <= ST_INPUT;
          mode_leds <= c_mode_input;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_seq_engine
// Description : Self-checking bench for simon_seq_engine; directed game
//               scenarios plus random play checked against a sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_seq_engine;

  localparam int N_BTN = 4;
  localparam int ADDR_W = 2;
  localparam int S = 3;
  localparam int DEPTH = 2**ADDR_W;

  localparam int PH_IN = 0, PH_PB = 1, PH_RP = 2, PH_DN = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             level = 1'b0;
  logic [N_BTN-1:0] pattern = '0;
  logic             enter = 1'b0;
  logic [N_BTN-1:0] pattern_leds;
  logic [2:0]       mode_leds;
  logic [ADDR_W:0]  seq_len;
  logic             fail;
  logic             full;

  int checks = 0;
  int errors = 0;

  simon_seq_engine #(.N_BTN(N_BTN), .ADDR_W(ADDR_W), .STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .level(level), .pattern(pattern), .enter(enter),
    .pattern_leds(pattern_leds), .mode_leds(mode_leds), .seq_len(seq_len),
    .fail(fail), .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: the stored sequence is a queue; display values are derived
  // from the number of cycles spent in the current phase.
  logic [N_BTN-1:0] m_seq[$];
  int               m_phase = PH_IN;
  int               m_c = 0;
  int               m_rep = 0;
  logic [N_BTN-1:0] m_leds = '0;
  logic [2:0]       m_mode = 3'b001;
  logic             m_fail = 1'b0;
  bit               m_valid = 1'b0;

  function automatic bit legal(input logic [N_BTN-1:0] p, input logic lv);
    return (p != 0) && (lv || $countones(p) == 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= PH_IN; m_leds <= '0; m_mode <= 3'b001; m_fail <= 1'b0;
      m_c <= 0; m_rep <= 0; m_valid <= 1'b1;
      m_seq.delete();
    end else begin
      m_fail <= 1'b0;
      case (m_phase)
        PH_IN: begin
          m_leds <= pattern;
          if (enter && legal(pattern, level) && m_seq.size() < DEPTH) begin
            m_seq.push_back(pattern);
            m_phase <= PH_PB; m_c <= 0; m_mode <= 3'b010;
          end
        end
        PH_PB: begin
          m_c <= m_c + 1;
          if (m_c + 1 == m_seq.size() * S) begin
            m_phase <= PH_RP; m_leds <= '0; m_mode <= 3'b100; m_rep <= 0;
          end else begin
            m_leds <= m_seq[m_c / S];
          end
        end
        PH_RP: begin
          m_leds <= pattern;
          if (enter) begin
            if (pattern == m_seq[m_rep]) begin
              if (m_rep != m_seq.size() - 1) m_rep <= m_rep + 1;
              else if (m_seq.size() == DEPTH) begin
                m_phase <= PH_DN; m_c <= 0; m_mode <= 3'b111;
              end else begin
                m_phase <= PH_IN; m_mode <= 3'b001;
              end
            end else begin
              m_fail <= 1'b1; m_phase <= PH_DN; m_c <= 0; m_mode <= 3'b111;
            end
          end
        end
        default: begin
          m_c <= m_c + 1;
          m_leds <= m_seq[(m_c / S) % m_seq.size()];
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (pattern_leds !== m_leds || mode_leds !== m_mode || fail !== m_fail ||
          int'(seq_len) != m_seq.size() || full !== (m_seq.size() == DEPTH)) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got leds=%b mode=%b len=%0d fail=%b full=%b expected leds=%b mode=%b len=%0d fail=%b full=%b",
                 $time, pattern_leds, mode_leds, seq_len, fail, full,
                 m_leds, m_mode, m_seq.size(), m_fail, (m_seq.size() == DEPTH));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press(input logic [N_BTN-1:0] p);
    pattern = p; enter = 1'b1; cyc();
    enter = 1'b0; cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; enter = 1'b0; cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic wait_mode(input logic [2:0] m, input string name);
    for (int i = 0; i < 200; i++) begin
      if (mode_leds == m) return;
      cyc();
    end
    checks++; errors++;
    $display("FAIL %s: timeout, got mode %b expected %b", name, mode_leds, m);
  endtask

  task automatic play_round(input logic [N_BTN-1:0] p);
    press(p);
    wait_mode(3'b100, "round_to_repeat");
    for (int k = 0; k < m_seq.size(); k++) press(m_seq[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_BTN-1:0] p;
    // Reset state
    rst = 1'b1; cyc(); cyc(); cyc();
    chk("rst_mode", int'(mode_leds), 1);
    chk("rst_leds", int'(pattern_leds), 0);
    chk("rst_len", int'(seq_len), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_full", int'(full), 0);
    rst = 1'b0;

    // Illegal two-hot pattern at level 0 is ignored
    level = 1'b0;
    press(4'b0011);
    chk("illegal_len", int'(seq_len), 0);
    chk("illegal_mode", int'(mode_leds), 1);

    // First round: playback timing then repeat
    pattern = 4'b0100; enter = 1'b1; cyc();
    enter = 1'b0;
    chk("pb_mode", int'(mode_leds), 2);
    chk("pb_leds_first", int'(pattern_leds), 4);
    repeat (S - 1) cyc();
    chk("pb_leds_last", int'(pattern_leds), 4);
    cyc();
    chk("rep_mode", int'(mode_leds), 4);
    chk("rep_leds", int'(pattern_leds), 0);
    press(4'b0100);
    chk("round1_mode", int'(mode_leds), 1);
    chk("round1_len", int'(seq_len), 1);

    // Two rounds 0001, 1000 with playback order check
    do_reset();
    play_round(4'b0001);
    press(4'b1000);
    chk("pb2_entry0", int'(pattern_leds), 1);
    repeat (S) cyc();
    chk("pb2_entry1", int'(pattern_leds), 8);
    wait_mode(3'b100, "pb2_to_repeat");
    press(4'b0001);
    press(4'b1000);
    chk("round2_len", int'(seq_len), 2);
    chk("round2_mode", int'(mode_leds), 1);

    // Failed repeat then endless replay
    do_reset();
    play_round(4'b0001);
    press(4'b1000);
    wait_mode(3'b100, "fail_to_repeat");
    pattern = 4'b0010; enter = 1'b1; cyc();
    enter = 1'b0;
    chk("fail_pulse", int'(fail), 1);
    chk("fail_mode", int'(mode_leds), 7);
    cyc();
    chk("fail_pulse_end", int'(fail), 0);
    chk("done_leds0", int'(pattern_leds), 1);
    repeat (S) cyc();
    chk("done_leds1", int'(pattern_leds), 8);
    repeat (S) cyc();
    chk("done_wrap", int'(pattern_leds), 1);
    press(4'b0100);
    chk("done_enter_ignored", int'(mode_leds), 7);

    // Fill the memory at level 1, then win
    do_reset();
    level = 1'b1;
    play_round(4'b0110);
    chk("level1_accept", int'(seq_len), 1);
    for (int r = 0; r < 2; r++) play_round(N_BTN'($urandom_range(1, 15)));
    p = N_BTN'($urandom_range(1, 15));
    press(p);
    chk("full_set", int'(full), 1);
    chk("full_len", int'(seq_len), 4);
    wait_mode(3'b100, "full_to_repeat");
    for (int k = 0; k < DEPTH - 1; k++) press(m_seq[k]);
    pattern = p; enter = 1'b1; cyc();
    enter = 1'b0;
    chk("win_mode", int'(mode_leds), 7);
    chk("win_fail", int'(fail), 0);
    press(4'b0001);
    chk("win_len_hold", int'(seq_len), 4);

    // Reset in the middle of playback
    do_reset();
    press(4'b0010);
    chk("mid_pb_mode", int'(mode_leds), 2);
    rst = 1'b1; cyc();
    chk("rst_mid_pb_mode", int'(mode_leds), 1);
    chk("rst_mid_pb_len", int'(seq_len), 0);
    rst = 1'b0;

    // Random play, mostly correct repeats
    for (int i = 0; i < 3000; i++) begin
      if ((m_phase == PH_DN && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        level = 1'($urandom);
      end else begin
        rst = 1'b0;
      end
      enter = ($urandom_range(0, 2) == 0);
      if (m_phase == PH_RP && m_seq.size() > 0 && $urandom_range(0, 9) != 0)
        pattern = m_seq[m_rep];
      else
        pattern = N_BTN'($urandom);
      cyc();
    end
    rst = 1'b0; enter = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
